stopwatch_bcd_counter: RTL and testbench

//   Consumes the square wave from the frequency divider (tick_in, 4 Hz nominal) and runs an MM:SS stopwatch.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/stopwatch_bcd_counter_bcd_digit.sv | 30 +++
 rtl/stopwatch_bcd_counter.sv | 101 ++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the MM:SS stopwatch: FSM states, BCD digit width and digit limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int BCD_W     = 4;
    localparam int DIG_MAX_9 = 9;
    localparam int DIG_MAX_5 = 5;

endpackage

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// One BCD digit that wraps at MAX; carry is combinational so a whole chain settles within one clk.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = DIG_MAX_9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] value,
    output logic             carry
);

    logic at_max;

    assign at_max = (value == BCD_W'(MAX));
    assign carry  = inc & at_max;

    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= at_max ? '0 : value + BCD_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS stopwatch: synchronises the divided tick, prescales its rising edges to seconds and counts in BCD.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 4,
    parameter int PS_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start_stop,
    input  logic             clear,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             running,
    output logic             rollover,
    output state_t           fsm_state
);

    logic            s1, s2, s3;
    logic            tick_edge;
    logic [PS_W-1:0] ps;
    logic            ps_last;
    logic            count_en;
    logic            sec_step;
    logic            c_so, c_st, c_mo, c_mt;
    state_t          state, state_nxt;

    // Synchroniser runs in every state so a pause never replays an old edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick_edge = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (!clear && start_stop) state_nxt = ST_RUN;
            ST_RUN:   if (clear) state_nxt = ST_IDLE;
                      else if (start_stop) state_nxt = ST_PAUSE;
            ST_PAUSE: if (clear) state_nxt = ST_IDLE;
                      else if (start_stop) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        running   = (state == ST_RUN);
        fsm_state = state;
    end

    // Counting keys off the current state, so RUN->PAUSE still counts and PAUSE->RUN does not.
    assign count_en = (state == ST_RUN) & tick_edge & ~clear;
    assign ps_last  = (ps == PS_W'(TICKS_PER_SEC - 1));
    assign sec_step = count_en & ps_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ps <= '0;
        end else if (clear || (state == ST_IDLE && start_stop)) begin
            ps <= '0;
        end else if (count_en) begin
            ps <= ps_last ? '0 : ps + PS_W'(1);
        end
    end

    bcd_digit #(.MAX(DIG_MAX_9)) u_sec_ones (
        .clk(clk), .reset(reset), .clr(clear), .inc(sec_step), .value(sec_ones), .carry(c_so)
    );
    bcd_digit #(.MAX(DIG_MAX_5)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(clear), .inc(c_so), .value(sec_tens), .carry(c_st)
    );
    bcd_digit #(.MAX(DIG_MAX_9)) u_min_ones (
        .clk(clk), .reset(reset), .clr(clear), .inc(c_st), .value(min_ones), .carry(c_mo)
    );
    bcd_digit #(.MAX(DIG_MAX_5)) u_min_tens (
        .clk(clk), .reset(reset), .clr(clear), .inc(c_mo), .value(min_tens), .carry(c_mt)
    );

    always_ff @(posedge clk) begin
        if (!reset) rollover <= 1'b0;
        else        rollover <= c_mt;
    end

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for the MM:SS stopwatch with TICKS_PER_SEC=4; inputs driven and outputs sampled on negedge.
module tb_stopwatch_bcd_counter;
    import stopwatch_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, rollover;
    state_t     fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_bcd_counter #(.TICKS_PER_SEC(4), .PS_W(8)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .rollover(rollover), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [15:0] exp);
        chk(tag, {16'h0, min_tens, min_ones, sec_tens, sec_ones}, {16'h0, exp});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cyc(1); clear = 1'b0;
    endtask

    // Two cycles high, two low; the count has settled when this returns.
    task automatic tick();
        tick_in = 1'b1; cyc(2); tick_in = 1'b0; cyc(2);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Dense edges for long runs, followed by enough cycles for the last edge to land.
    task automatic fast_secs(input int n);
        repeat (n * 4) begin
            tick_in = 1'b1; cyc(1); tick_in = 1'b0; cyc(1);
        end
        cyc(2);
    endtask

    initial begin
        // Reset held for 3 cycles with tick_in toggling
        reset = 1'b0;
        repeat (3) begin tick_in = ~tick_in; cyc(1); end
        tick_in = 1'b0;
        chk_time("reset_digits", 16'h0000);
        chk("reset_running", running, 0);
        chk("reset_rollover", rollover, 0);
        chk("reset_state", fsm_state, ST_IDLE);
        reset = 1'b1;
        cyc(2);
        ticks(5);
        chk_time("idle_no_count", 16'h0000);
        chk("idle_state", fsm_state, ST_IDLE);

        // Basic count with latency check on the 4th edge
        pulse_ss();
        chk("run_running", running, 1);
        ticks(3);
        chk_time("three_edges", 16'h0000);
        tick_in = 1'b1;
        cyc(2);
        chk_time("latency_before", 16'h0000);
        cyc(1);
        chk_time("latency_at", 16'h0001);
        tick_in = 1'b0;
        cyc(2);
        ticks(4);
        chk_time("basic_0002", 16'h0002);
        chk("basic_running", running, 1);

        // Pause/resume keeps the partial second
        pulse_clear();
        chk_time("clear_digits", 16'h0000);
        chk("clear_state", fsm_state, ST_IDLE);
        pulse_ss();
        ticks(2);
        pulse_ss();
        chk("pause_state", fsm_state, ST_PAUSE);
        chk("pause_running", running, 0);
        ticks(5);
        chk_time("pause_ignored", 16'h0000);
        pulse_ss();
        ticks(2);
        chk_time("resume_0001", 16'h0001);

        // Clear coincident with tick_edge at 00:03
        pulse_clear();
        pulse_ss();
        ticks(12);
        chk_time("pre_collide_0003", 16'h0003);
        tick_in = 1'b1;
        cyc(2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        tick_in = 1'b0;
        chk_time("clear_tick_digits", 16'h0000);
        chk("clear_tick_state", fsm_state, ST_IDLE);
        cyc(2);
        pulse_ss();
        ticks(4);
        chk_time("after_clear_0001", 16'h0001);

        // PAUSE->RUN coincident with tick_edge: tick dropped, prescaler stays at 1
        tick();
        pulse_ss();
        tick_in = 1'b1;
        cyc(2);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        tick_in = 1'b0;
        cyc(2);
        chk("resume_tick_state", fsm_state, ST_RUN);
        ticks(2);
        chk_time("resume_tick_hold", 16'h0001);
        tick();
        chk_time("resume_tick_0002", 16'h0002);

        // RUN->PAUSE coincident with tick_edge: tick counted
        ticks(3);
        tick_in = 1'b1;
        cyc(2);
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
        tick_in = 1'b0;
        cyc(2);
        chk_time("pause_tick_0003", 16'h0003);
        chk("pause_tick_state", fsm_state, ST_PAUSE);

        // Carry chain and full wrap
        pulse_clear();
        pulse_ss();
        fast_secs(59);
        chk_time("carry_0059", 16'h0059);
        fast_secs(1);
        chk_time("carry_0100", 16'h0100);
        fast_secs(3538);
        chk_time("carry_5958", 16'h5958);
        fast_secs(1);
        chk_time("carry_5959", 16'h5959);
        ticks(3);
        tick_in = 1'b1;
        cyc(2);
        chk_time("wrap_before", 16'h5959);
        chk("wrap_roll_before", rollover, 0);
        cyc(1);
        chk_time("wrap_0000", 16'h0000);
        chk("wrap_roll_high", rollover, 1);
        chk("wrap_running", running, 1);
        cyc(1);
        chk("wrap_roll_low", rollover, 0);
        tick_in = 1'b0;
        cyc(1);

        // Mid-run reset at 12:34
        pulse_clear();
        pulse_ss();
        fast_secs(754);
        chk_time("pre_reset_1234", 16'h1234);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        chk_time("midreset_digits", 16'h0000);
        chk("midreset_state", fsm_state, ST_IDLE);
        cyc(1);
        pulse_ss();
        ticks(4);
        chk_time("post_reset_0001", 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
